maze_memory: RTL
================

# maze_memory

Holds the 16x16 maze wall map and the per-cell visited map for the maze-solver datapath. It is the stage directly upstream of the solver datapath. It is loaded row by row over a valid/ready stream. It answers the datapath's `x_pos`/`y_pos`/`rd` queries with wall and visited bits at one-cycle latency, and accepts visited marks. It sequences load and clear sweeps with a small FSM and reports when the maze is usable.

## Interface
Parameters:
- `N`, 16: maze side. Fixed at 16 in this design; coordinates are 4 bits.

Ports:
- `cl`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `load_start`  in  1  begin loading a new maze.
- `load_valid`  in  1  `load_data` holds a valid row.
- `load_data`  in  16  one maze row; bit x = wall at (x, row).
- `load_ready`  out  1  block accepts a row this cycle.
- `load_done`  out  1  one-cycle pulse when a load and its clear sweep complete.
- `maze_ok`  out  1  maze is loaded and the block is in READY.
- `busy`  out  1  high in LOAD or CLEAR.
- `bad_maze`  out  1  latched: the loaded maze has a wall at (0,0) or (15,15).
- `x_pos`, `y_pos`  in  4 each  query/mark cell coordinates.
- `rd`  in  1  read request for (`x_pos`, `y_pos`).
- `rd_valid`  out  1  `wall`/`visited` are valid; asserted one cycle after an accepted `rd`.
- `wall`  out  1  wall bit of the queried cell.
- `visited`  out  1  visited bit of the queried cell.
- `mark`  in  1  set the visited bit at (`x_pos`, `y_pos`).
- `clr_visited`  in  1  request a clear sweep of the visited map.
- `err`  out  1  one-cycle pulse when a `load_start` or `clr_visited` request is ignored.

## Operation
- States: CLEAR, IDLE, LOAD, READY. A 4-bit row counter `cnt` is shared by LOAD and CLEAR.
- **Reset:**
  - Enters CLEAR with `cnt`=0.
  - `maze_ok`, `bad_maze`, `load_done`, `rd_valid`, `wall`, `visited` and `err` are all 0.
  - Wall contents are not cleared.
- **CLEAR:**
  - Writes visited row `cnt` to all zeros; `cnt`++ each cycle.
  - After row 15, goes to READY if a maze is loaded, otherwise to IDLE.
- **IDLE:**
  - `load_start` → LOAD with `cnt`=0.
  - `rd`, `mark` and `clr_visited` are ignored.
- **LOAD:**
  - `load_ready`=1.
  - Each cycle with `load_valid`, writes wall row `cnt` from `load_data` and increments `cnt`.
  - Accepting row 15 → CLEAR, and `maze_ok` is cleared.
- **READY:**
  - Priority: `load_start` (→ LOAD) > `clr_visited` (→ CLEAR) > `rd`/`mark`.
  - `rd` registers `wall[y][x]` and `visited[y][x]` and sets `rd_valid` the next cycle.
  - `mark` sets `visited[y][x]`.
  - `rd` and `mark` may be asserted together on the same cell: `rd` returns the pre-mark value (read-before-write).
- **Completion of a load:**
  - `load_done` pulses in the first READY cycle after CLEAR.
  - `bad_maze` is recomputed from wall bits (0,0) and (15,15) at that point.
- **Ignored requests:**
  - `load_start` or `clr_visited` during LOAD or CLEAR is dropped and pulses `err`.
  - `rd` or `mark` outside READY is ignored silently; `rd_valid` stays 0.
- **Reset mid-operation:**
  - Aborts LOAD or CLEAR.
  - The partially written wall map is invalid; `maze_ok` stays 0 until a full load completes.

## Timing
- Read latency: exactly 1 cycle. `rd_valid` is high for one cycle per accepted `rd`; back-to-back reads give back-to-back results.
- `mark` takes effect at the clock edge on which it is sampled. A `rd` of the same cell in the next cycle returns 1.
- Load takes at least 16 accepted rows plus 16 clear cycles. With `load_valid` held high, `load_done` occurs 33 cycles after the `load_start` edge.
- Stalling `load_valid` holds `cnt` and the contents unchanged; there is no timeout.
- `wall`/`visited` hold their last value when `rd_valid`=0.
- `busy` is the combinational decode of the registered state.
- `maze_ok`=1 exactly when the state is READY.

## Structure
- Package `maze_pkg` holds:
  - the state encoding enum (CLEAR, IDLE, LOAD, READY);
  - constants `MAZE_N`=16, `COORD_W`=4, `START_X`/`START_Y`=0, `END_X`/`END_Y`=15. The solver's end comparator shares the end constants.
- Sub-module `bitmap_16x16`:
  - registered 16x16 bit array;
  - ports: row write (`row_we`, `row_idx`, `row_data`), single-bit set (`bit_set`, `x`, `y`), registered bit read;
  - instantiated once for walls and once for visited.
- The top level contains the FSM, `cnt`, and the output registers.

## Test plan
- Reset, then hold `rst`=0 for 16 cycles → IDLE, `maze_ok`=0. A `rd` during those cycles gives `rd_valid`=0.
- `load_start`, then 16 rows with `load_valid` held high; row y = 16'h0001<<y (diagonal walls) → `load_done` pulses at cycle 33 and `maze_ok`=1. `rd` at (3,3) gives `wall`=1 one cycle later; `rd` at (4,3) gives `wall`=0.
- Load with row 0 = 16'h0001 → `bad_maze`=1 on `load_done`. Reload with row 0 = 16'h0000 → `bad_maze`=0.
- In READY, `mark`+`rd` at (5,7) in the same cycle → `visited`=0. `rd` at (5,7) in the next cycle → `visited`=1. `clr_visited`, wait 16 cycles, `rd` at (5,7) → `visited`=0.
- During LOAD, drop `load_valid` for 5 cycles after row 7 → `cnt` holds and `load_done` is delayed by 5. A `load_start` in that gap → `err` pulse and no restart.
- Assert `rst` after row 9 of a load → CLEAR then IDLE, `maze_ok`=0. A fresh full load afterwards completes normally.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze memory and the solver datapath.
package maze_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_LOAD  = 2'd2,
      ST_READY = 2'd3
   } maze_state_t;

   localparam int MAZE_N  = 16;
   localparam int COORD_W = 4;

   localparam logic [COORD_W-1:0] START_X = 4'd0;
   localparam logic [COORD_W-1:0] START_Y = 4'd0;
   localparam logic [COORD_W-1:0] END_X   = 4'd15;
   localparam logic [COORD_W-1:0] END_Y   = 4'd15;

endpackage

// File: rtl/maze_memory_bitmap.sv
// 16x16 bit array with whole-row write, single-bit set and a registered bit read.
module bitmap_16x16
   import maze_pkg::*;
(
   input  logic               cl,
   input  logic               rst,
   input  logic               row_we,
   input  logic [COORD_W-1:0] row_idx,
   input  logic [MAZE_N-1:0]  row_data,
   input  logic               bit_set,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               rd_en,
   output logic               rd_bit
);

   logic [MAZE_N-1:0] bits_r [MAZE_N];
   logic              rd_bit_r;

   // storage array: contents deliberately survive reset
   always_ff @(posedge cl) begin
      if (row_we) begin
         bits_r[row_idx] <= row_data;
      end
      if (bit_set) begin
         bits_r[y][x] <= 1'b1;
      end
   end

   // read register: samples the pre-write value, so a same-edge set is not seen
   always_ff @(posedge cl) begin
      if (rst) begin
         rd_bit_r <= 1'b0;
      end else if (rd_en) begin
         rd_bit_r <= bits_r[y][x];
      end
   end

   assign rd_bit = rd_bit_r;

endmodule

// File: rtl/maze_memory.sv
// Maze wall/visited store: row-stream loader, visited clear sweep and 1-cycle cell queries.
module maze_memory
   import maze_pkg::*;
#(
   parameter int N = 16
) (
   input  logic               cl,
   input  logic               rst,
   input  logic               load_start,
   input  logic               load_valid,
   input  logic [N-1:0]       load_data,
   output logic               load_ready,
   output logic               load_done,
   output logic               maze_ok,
   output logic               busy,
   output logic               bad_maze,
   input  logic [COORD_W-1:0] x_pos,
   input  logic [COORD_W-1:0] y_pos,
   input  logic               rd,
   output logic               rd_valid,
   output logic               wall,
   output logic               visited,
   input  logic               mark,
   input  logic               clr_visited,
   output logic               err
);

   maze_state_t        state_r, state_nx_s;
   logic [COORD_W-1:0] cnt_r, cnt_nx_s;
   logic               loaded_r, loaded_nx_s;
   logic               pend_r, pend_nx_s;
   logic               done_r, done_nx_s;
   logic               err_r, err_nx_s;
   logic               maze_ok_r, rd_valid_r, bad_maze_r;
   logic               bad_start_r, bad_end_r;
   logic               wall_we_s, vis_clr_s, rd_acc_s, mark_acc_s;

   // next-state and per-cycle strobes
   always_comb begin
      state_nx_s  = state_r;
      cnt_nx_s    = cnt_r;
      loaded_nx_s = loaded_r;
      pend_nx_s   = pend_r;
      done_nx_s   = 1'b0;
      err_nx_s    = 1'b0;
      wall_we_s   = 1'b0;
      vis_clr_s   = 1'b0;
      rd_acc_s    = 1'b0;
      mark_acc_s  = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            vis_clr_s = 1'b1;
            cnt_nx_s  = cnt_r + 4'd1;
            err_nx_s  = load_start | clr_visited;
            if (cnt_r == END_Y) begin
               state_nx_s = loaded_r ? ST_READY : ST_IDLE;
               done_nx_s  = loaded_r & pend_r;
               pend_nx_s  = 1'b0;
            end else begin
               state_nx_s = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            if (load_start) begin
               state_nx_s  = ST_LOAD;
               cnt_nx_s    = 4'd0;
               loaded_nx_s = 1'b0;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            err_nx_s = load_start | clr_visited;
            if (load_valid) begin
               wall_we_s = 1'b1;
               cnt_nx_s  = cnt_r + 4'd1;
               if (cnt_r == END_Y) begin
                  state_nx_s  = ST_CLEAR;
                  loaded_nx_s = 1'b1;
                  pend_nx_s   = 1'b1;
               end else begin
                  state_nx_s = ST_LOAD;
               end
            end else begin
               state_nx_s = ST_LOAD;
            end
         end
         ST_READY: begin
            if (load_start) begin
               state_nx_s  = ST_LOAD;
               cnt_nx_s    = 4'd0;
               loaded_nx_s = 1'b0;
            end else if (clr_visited) begin
               state_nx_s = ST_CLEAR;
               cnt_nx_s   = 4'd0;
            end else begin
               rd_acc_s   = rd;
               mark_acc_s = mark;
            end
         end
         default: begin
            state_nx_s  = ST_CLEAR;
            cnt_nx_s    = 4'd0;
            loaded_nx_s = 1'b0;
            pend_nx_s   = 1'b0;
         end
      endcase
   end

   // state, counter and registered status outputs
   always_ff @(posedge cl) begin
      if (rst) begin
         state_r     <= ST_CLEAR;
         cnt_r       <= 4'd0;
         loaded_r    <= 1'b0;
         pend_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         maze_ok_r   <= 1'b0;
         rd_valid_r  <= 1'b0;
         bad_maze_r  <= 1'b0;
         bad_start_r <= 1'b0;
         bad_end_r   <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         cnt_r      <= cnt_nx_s;
         loaded_r   <= loaded_nx_s;
         pend_r     <= pend_nx_s;
         done_r     <= done_nx_s;
         err_r      <= err_nx_s;
         maze_ok_r  <= (state_nx_s == ST_READY);
         rd_valid_r <= rd_acc_s;
         // corner walls are snooped off the load stream and published with load_done
         if (wall_we_s && (cnt_r == START_Y)) begin
            bad_start_r <= load_data[START_X];
         end
         if (wall_we_s && (cnt_r == END_Y)) begin
            bad_end_r <= load_data[END_X];
         end
         if (done_nx_s) begin
            bad_maze_r <= bad_start_r | bad_end_r;
         end
      end
   end

   bitmap_16x16 u_walls (
      .cl       (cl),
      .rst      (rst),
      .row_we   (wall_we_s),
      .row_idx  (cnt_r),
      .row_data (load_data),
      .bit_set  (1'b0),
      .x        (x_pos),
      .y        (y_pos),
      .rd_en    (rd_acc_s),
      .rd_bit   (wall)
   );

   bitmap_16x16 u_visited (
      .cl       (cl),
      .rst      (rst),
      .row_we   (vis_clr_s),
      .row_idx  (cnt_r),
      .row_data (16'h0000),
      .bit_set  (mark_acc_s),
      .x        (x_pos),
      .y        (y_pos),
      .rd_en    (rd_acc_s),
      .rd_bit   (visited)
   );

   assign load_ready = (state_r == ST_LOAD);
   assign busy       = (state_r == ST_LOAD) || (state_r == ST_CLEAR);
   assign maze_ok    = maze_ok_r;
   assign load_done  = done_r;
   assign err        = err_r;
   assign rd_valid   = rd_valid_r;
   assign bad_maze   = bad_maze_r;

endmodule
